regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: rst  in  1  synchronous reset, active-low (0 = reset).
REQ-003 The block SHALL have ports: a_valid/a_reg/a_data  in  1/4/16  requester A (ALU writeback) request, target register, data.
REQ-004 The block SHALL have ports: a_ready  out  1  A accepted this cycle (combinational).
REQ-005 The block SHALL have ports: b_valid/b_reg/b_data  in  1/4/16, and b_ready  out  1; requester B (load writeback), same meaning as A.
REQ-006 The block SHALL have ports: rsv_valid/rsv_reg  in  1/4  mark rsv_reg as pending-write (issue-time reservation).
REQ-007 The block SHALL have ports: rd_reg1/rd_reg2  in  4/4  registers being read; rd_busy1/rd_busy2  out  1/1  read must stall (combinational).
REQ-008 The block SHALL have ports: WriteReg/DstReg/DstData  out  1/4/16  registered register-file write port.
REQ-009 The block SHALL have ports: busy_vec  out  16  pending-write bit per register; rsv_err  out  1  sticky double-reservation flag.

Function
REQ-010 Accept = valid & ready; at most one of a_ready/b_ready SHALL be 1 in any cycle; ready never asserted without its valid.
REQ-011 Arbiter FSM states NORM, FAIR: in NORM, A has priority (a_ready = a_valid; b_ready = b_valid & !a_valid); in FAIR, B has priority.
REQ-012 2-bit saturating counter b_wait SHALL increment each cycle b_valid=1 and b_ready=0, and clear on any B accept.
REQ-013 NORM->FAIR when b_wait reaches 3 (at that edge); FAIR->NORM on the edge of a B accept; FAIR with b_valid=0 returns to NORM next edge.
REQ-014 Latency: request accepted in cycle N SHALL produce WriteReg=1, DstReg/DstData = accepted reg/data in cycle N+1; no accept in N -> WriteReg=0 in N+1.
REQ-015 Output stage never stalls; back-to-back accepts SHALL produce back-to-back writes.
REQ-016 rsv_valid=1 SHALL set busy_vec[rsv_reg] at the edge.
REQ-017 busy_vec[DstReg] SHALL clear at the edge ending a cycle with WriteReg=1.
REQ-018 Same-edge set and clear of the same register: set wins (bit remains 1).
REQ-019 rsv_valid to a register already busy (and not simultaneously clearing) SHALL set rsv_err, held until reset; busy bit stays 1.
REQ-020 rd_busyX = busy_vec[rd_regX], subject to REQ-025.
REQ-021 Writes to a non-busy register SHALL still be performed; busy bit stays 0.

Reset
REQ-022 While rst=0 at an edge: WriteReg=0, DstReg=0, DstData=0, busy_vec=0, rsv_err=0, b_wait=0, state=NORM.
REQ-023 Requests presented during reset SHALL not be accepted (a_ready=b_ready=0 while rst=0); an accept in the cycle reset asserts is discarded.

Configuration
REQ-024 Macro REGFILE_WB_BYPASS_EN selects write-to-read forwarding.
REQ-025 Defined: rd_busyX=0 when WriteReg=1 and DstReg=rd_regX, and outputs fwd_data1/fwd_data2 (16 bits) SHALL equal DstData in that case, else 0; undefined: no fwd ports, rd_busyX strictly per REQ-020.

Verification
REQ-026 a_valid=b_valid=1 for 5 cycles (NORM, regs 3/7) -> A accepted cycles 0-2, B accepted cycle 3, A cycle 4; WriteReg=1 cycles 1-5.
REQ-027 rsv_valid, rsv_reg=5 at cycle 0; b_valid, b_reg=5, b_data=0xBEEF at cycle 2 -> busy_vec[5]=1 cycles 1-3, WriteReg=1 DstReg=5 DstData=0xBEEF cycle 3, busy_vec[5]=0 cycle 4.
REQ-028 rsv_reg=9 reserved twice with no write -> rsv_err=1 after second edge, stays 1 until rst=0.
REQ-029 Write to reg 2 in flight while rsv_reg=2 same edge -> busy_vec[2]=1 afterwards; rsv_err=0.
REQ-030 With REGFILE_WB_BYPASS_EN: rd_reg1=4 busy, WriteReg=1 DstReg=4 DstData=0x1234 -> rd_busy1=0, fwd_data1=0x1234; without macro -> rd_busy1=1.
REQ-031 rst=0 asserted mid-burst with WriteReg=1 -> next cycle all outputs 0, state NORM, busy_vec=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a 16x16 register file: merges ALU (A) and load (B) results into one
// registered write port and tracks pending-write reservations. Define REGFILE_WB_BYPASS_EN for forwarding.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [3:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ready,
    input  logic        rsv_valid,
    input  logic [3:0]  rsv_reg,
    input  logic [3:0]  rd_reg1,
    input  logic [3:0]  rd_reg2,
    output logic        rd_busy1,
    output logic        rd_busy2,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic [15:0] busy_vec,
    output logic        rsv_err
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic [15:0] fwd_data1,
    output logic [15:0] fwd_data2
`endif
);

    typedef enum logic {
        NORM = 1'b0,
        FAIR = 1'b1
    } arbState_t;

    arbState_t   stateReg;
    arbState_t   stateNext;
    logic [1:0]  bWaitReg;
    logic [1:0]  bWaitNext;
    logic        aReady;
    logic        bReady;
    logic        aAccept;
    logic        bAccept;

    logic        wrValidReg;
    logic [3:0]  dstRegReg;
    logic [15:0] dstDataReg;
    logic [15:0] busyReg;
    logic [15:0] busyNext;
    logic        rsvErrReg;
    logic        rsvConflict;

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg <= NORM;
            bWaitReg <= 2'd0;
        end else begin
            stateReg <= stateNext;
            bWaitReg <= bWaitNext;
        end
    end

    // Next-state logic; the starvation counter saturates at 3 and clears on any B accept
    always_comb begin
        bWaitNext = bWaitReg;
        if (bAccept) begin
            bWaitNext = 2'd0;
        end else if (b_valid && !bReady && (bWaitReg != 2'd3)) begin
            bWaitNext = bWaitReg + 2'd1;
        end

        stateNext = stateReg;
        case (stateReg)
            NORM: begin
                if (bWaitNext == 2'd3) begin
                    stateNext = FAIR;
                end
            end
            FAIR: begin
                if (bAccept || !b_valid) begin
                    stateNext = NORM;
                end
            end
            default: stateNext = NORM;
        endcase
    end

    // Grant logic; nothing is granted while reset is held
    always_comb begin
        aReady = 1'b0;
        bReady = 1'b0;
        if (rst) begin
            case (stateReg)
                NORM: begin
                    aReady = a_valid;
                    bReady = b_valid && !a_valid;
                end
                FAIR: begin
                    bReady = b_valid;
                    aReady = a_valid && !b_valid;
                end
                default: begin
                    aReady = 1'b0;
                    bReady = 1'b0;
                end
            endcase
        end
    end

    assign a_ready = aReady;
    assign b_ready = bReady;
    assign aAccept = a_valid && aReady;
    assign bAccept = b_valid && bReady;

    // Single-entry output stage, refilled every cycle so it never stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrValidReg <= 1'b0;
            dstRegReg  <= 4'd0;
            dstDataReg <= 16'd0;
        end else begin
            wrValidReg <= aAccept || bAccept;
            if (aAccept) begin
                dstRegReg  <= a_reg;
                dstDataReg <= a_data;
            end else if (bAccept) begin
                dstRegReg  <= b_reg;
                dstDataReg <= b_data;
            end
        end
    end

    // Per-register pending-write bits; a reservation on the same edge as the retiring write wins
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_busy
            logic setBit;
            logic clrBit;
            assign setBit       = rsv_valid && (rsv_reg == 4'(gi));
            assign clrBit       = wrValidReg && (dstRegReg == 4'(gi));
            assign busyNext[gi] = setBit || (busyReg[gi] && !clrBit);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    busyReg[gi] <= 1'b0;
                end else begin
                    busyReg[gi] <= busyNext[gi];
                end
            end
        end
    endgenerate

    assign rsvConflict = rsv_valid && busyReg[rsv_reg] &&
                         !(wrValidReg && (dstRegReg == rsv_reg));

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsvErrReg <= 1'b0;
        end else if (rsvConflict) begin
            rsvErrReg <= 1'b1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic fwdHit1;
    logic fwdHit2;

    // The write retiring this cycle satisfies a matching read directly
    assign fwdHit1   = wrValidReg && (dstRegReg == rd_reg1);
    assign fwdHit2   = wrValidReg && (dstRegReg == rd_reg2);
    assign rd_busy1  = busyReg[rd_reg1] && !fwdHit1;
    assign rd_busy2  = busyReg[rd_reg2] && !fwdHit2;
    assign fwd_data1 = fwdHit1 ? dstDataReg : 16'd0;
    assign fwd_data2 = fwdHit2 ? dstDataReg : 16'd0;
`else
    assign rd_busy1  = busyReg[rd_reg1];
    assign rd_busy2  = busyReg[rd_reg2];
`endif

    assign WriteReg = wrValidReg;
    assign DstReg   = dstRegReg;
    assign DstData  = dstDataReg;
    assign busy_vec = busyReg;
    assign rsv_err  = rsvErrReg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: arbitration, latency, reservations, reset, forwarding.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [3:0]  a_reg;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_reg;
    logic [15:0] b_data;
    logic        b_ready;
    logic        rsv_valid;
    logic [3:0]  rsv_reg;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic        rd_busy1;
    logic        rd_busy2;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [15:0] busy_vec;
    logic        rsv_err;
`ifdef REGFILE_WB_BYPASS_EN
    logic [15:0] fwd_data1;
    logic [15:0] fwd_data2;
`endif

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .busy_vec(busy_vec), .rsv_err(rsv_err)
`ifdef REGFILE_WB_BYPASS_EN
        , .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        rsv_valid = 0; rsv_reg = 0;
        rd_reg1 = 0; rd_reg2 = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 0;
        a_valid = 1; b_valid = 1; rsv_valid = 1; rsv_reg = 4'd3;
        #1;
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            $display("FAIL reset_ready: a_ready=%b b_ready=%b, expected 0 0", a_ready, b_ready);
            miscompares++;
        end
        tick();
        tick();
        vectors++;
        if (WriteReg !== 1'b0 || DstReg !== 4'd0 || DstData !== 16'd0) begin
            $display("FAIL reset_out: WriteReg=%b DstReg=%0d DstData=%h, expected 0 0 0000", WriteReg, DstReg, DstData);
            miscompares++;
        end
        vectors++;
        if (busy_vec !== 16'h0000 || rsv_err !== 1'b0) begin
            $display("FAIL reset_busy: busy_vec=%h rsv_err=%b, expected 0000 0", busy_vec, rsv_err);
            miscompares++;
        end
        idle_inputs();
        rst = 1;
        tick();
        $display("test_reset done");
    endtask

    // Both requesters active for 5 cycles: A,A,A then B by fairness, then A
    task automatic test_priority;
        logic [4:0] expA = 5'b10111;
        logic [4:0] expB = 5'b01000;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a_valid = 1; a_reg = 4'd3; a_data = 16'h1000 + 16'(i);
            b_valid = 1; b_reg = 4'd7; b_data = 16'h2000 + 16'(i);
            #1;
            vectors++;
            if (a_ready !== expA[i] || b_ready !== expB[i]) begin
                $display("FAIL prio_grant[%0d]: a_ready=%b b_ready=%b, expected %b %b", i, a_ready, b_ready, expA[i], expB[i]);
                miscompares++;
            end
            tick();
            vectors++;
            if (WriteReg !== 1'b1 || DstReg !== (expA[i] ? 4'd3 : 4'd7) ||
                DstData !== (expA[i] ? (16'h1000 + 16'(i)) : (16'h2000 + 16'(i)))) begin
                $display("FAIL prio_write[%0d]: WriteReg=%b DstReg=%0d DstData=%h", i, WriteReg, DstReg, DstData);
                miscompares++;
            end
            $display("prio cycle %0d: DstReg=%0d DstData=%h", i, DstReg, DstData);
        end
        idle_inputs();
        #1;
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            $display("FAIL idle_ready: a_ready=%b b_ready=%b, expected 0 0", a_ready, b_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (WriteReg !== 1'b0 || busy_vec !== 16'h0000) begin
            $display("FAIL idle_write: WriteReg=%b busy_vec=%h, expected 0 0000", WriteReg, busy_vec);
            miscompares++;
        end
    endtask

    // A B accept part-way resets the starvation count
    task automatic test_wait_clear;
        logic [6:0] av   = 7'b1111011;
        logic [6:0] expA = 7'b0111011;
        logic [6:0] expB = 7'b1000100;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            a_valid = av[i]; a_reg = 4'd1; a_data = 16'h00A0 + 16'(i);
            b_valid = 1;     b_reg = 4'd2; b_data = 16'h00B0 + 16'(i);
            #1;
            vectors++;
            if (a_ready !== expA[i] || b_ready !== expB[i]) begin
                $display("FAIL wait_grant[%0d]: a_ready=%b b_ready=%b, expected %b %b", i, a_ready, b_ready, expA[i], expB[i]);
                miscompares++;
            end
            tick();
            vectors++;
            if (WriteReg !== 1'b1 || DstReg !== (expA[i] ? 4'd1 : 4'd2)) begin
                $display("FAIL wait_write[%0d]: WriteReg=%b DstReg=%0d", i, WriteReg, DstReg);
                miscompares++;
            end
            $display("wait cycle %0d: DstReg=%0d", i, DstReg);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reservation;
        do_reset();
        rsv_valid = 1; rsv_reg = 4'd5; rd_reg1 = 4'd5;
        tick();
        rsv_valid = 0;
        vectors++;
        if (busy_vec !== 16'h0020 || rd_busy1 !== 1'b1) begin
            $display("FAIL rsv_c1: busy_vec=%h rd_busy1=%b, expected 0020 1", busy_vec, rd_busy1);
            miscompares++;
        end
        tick();
        vectors++;
        if (busy_vec !== 16'h0020) begin
            $display("FAIL rsv_c2: busy_vec=%h, expected 0020", busy_vec);
            miscompares++;
        end
        b_valid = 1; b_reg = 4'd5; b_data = 16'hBEEF;
        tick();
        b_valid = 0;
        vectors++;
        if (WriteReg !== 1'b1 || DstReg !== 4'd5 || DstData !== 16'hBEEF || busy_vec !== 16'h0020) begin
            $display("FAIL rsv_c3: WriteReg=%b DstReg=%0d DstData=%h busy_vec=%h, expected 1 5 beef 0020", WriteReg, DstReg, DstData, busy_vec);
            miscompares++;
        end
        tick();
        vectors++;
        if (busy_vec !== 16'h0000 || WriteReg !== 1'b0 || rsv_err !== 1'b0) begin
            $display("FAIL rsv_c4: busy_vec=%h WriteReg=%b rsv_err=%b, expected 0000 0 0", busy_vec, WriteReg, rsv_err);
            miscompares++;
        end
        $display("test_reservation done: busy_vec=%h", busy_vec);
        idle_inputs();
    endtask

    task automatic test_double_rsv;
        do_reset();
        rsv_valid = 1; rsv_reg = 4'd9;
        tick();
        vectors++;
        if (rsv_err !== 1'b0 || busy_vec !== 16'h0200) begin
            $display("FAIL dbl_first: rsv_err=%b busy_vec=%h, expected 0 0200", rsv_err, busy_vec);
            miscompares++;
        end
        tick();
        rsv_valid = 0;
        vectors++;
        if (rsv_err !== 1'b1 || busy_vec !== 16'h0200) begin
            $display("FAIL dbl_second: rsv_err=%b busy_vec=%h, expected 1 0200", rsv_err, busy_vec);
            miscompares++;
        end
        tick();
        tick();
        vectors++;
        if (rsv_err !== 1'b1) begin
            $display("FAIL dbl_sticky: rsv_err=%b, expected 1", rsv_err);
            miscompares++;
        end
        rst = 0;
        tick();
        rst = 1;
        vectors++;
        if (rsv_err !== 1'b0 || busy_vec !== 16'h0000) begin
            $display("FAIL dbl_clear: rsv_err=%b busy_vec=%h, expected 0 0000", rsv_err, busy_vec);
            miscompares++;
        end
        $display("test_double_rsv done: rsv_err=%b", rsv_err);
    endtask

    task automatic test_same_edge;
        do_reset();
        rsv_valid = 1; rsv_reg = 4'd2;
        tick();
        rsv_valid = 0;
        a_valid = 1; a_reg = 4'd2; a_data = 16'h5555;
        tick();
        a_valid = 0;
        rsv_valid = 1; rsv_reg = 4'd2;
        tick();
        rsv_valid = 0;
        vectors++;
        if (busy_vec !== 16'h0004 || rsv_err !== 1'b0) begin
            $display("FAIL same_edge: busy_vec=%h rsv_err=%b, expected 0004 0", busy_vec, rsv_err);
            miscompares++;
        end
        tick();
        vectors++;
        if (busy_vec !== 16'h0004) begin
            $display("FAIL same_edge_hold: busy_vec=%h, expected 0004", busy_vec);
            miscompares++;
        end
        $display("test_same_edge done: busy_vec=%h", busy_vec);
        idle_inputs();
    endtask

    task automatic test_bypass;
        logic expBusy;
`ifdef REGFILE_WB_BYPASS_EN
        expBusy = 1'b0;
`else
        expBusy = 1'b1;
`endif
        do_reset();
        rsv_valid = 1; rsv_reg = 4'd4;
        tick();
        rsv_valid = 0; rd_reg1 = 4'd4; rd_reg2 = 4'd4;
        #1;
        vectors++;
        if (rd_busy1 !== 1'b1 || rd_busy2 !== 1'b1) begin
            $display("FAIL byp_pending: rd_busy1=%b rd_busy2=%b, expected 1 1", rd_busy1, rd_busy2);
            miscompares++;
        end
        a_valid = 1; a_reg = 4'd4; a_data = 16'h1234;
        tick();
        a_valid = 0;
        #1;
        vectors++;
        if (rd_busy1 !== expBusy || rd_busy2 !== expBusy) begin
            $display("FAIL byp_write: rd_busy1=%b rd_busy2=%b, expected %b %b", rd_busy1, rd_busy2, expBusy, expBusy);
            miscompares++;
        end
`ifdef REGFILE_WB_BYPASS_EN
        vectors++;
        if (fwd_data1 !== 16'h1234 || fwd_data2 !== 16'h1234) begin
            $display("FAIL byp_fwd: fwd_data1=%h fwd_data2=%h, expected 1234 1234", fwd_data1, fwd_data2);
            miscompares++;
        end
`endif
        tick();
        vectors++;
        if (rd_busy1 !== 1'b0 || busy_vec !== 16'h0000) begin
            $display("FAIL byp_after: rd_busy1=%b busy_vec=%h, expected 0 0000", rd_busy1, busy_vec);
            miscompares++;
        end
        $display("test_bypass done: rd_busy1=%b", rd_busy1);
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        rsv_valid = 1; rsv_reg = 4'd6;
        tick();
        rsv_valid = 0;
        a_valid = 1; a_reg = 4'd6; a_data = 16'hA5A5;
        b_valid = 1; b_reg = 4'd8; b_data = 16'h5A5A;
        tick();
        vectors++;
        if (WriteReg !== 1'b1 || DstData !== 16'hA5A5) begin
            $display("FAIL mid_pre: WriteReg=%b DstData=%h, expected 1 a5a5", WriteReg, DstData);
            miscompares++;
        end
        rst = 0;
        #1;
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            $display("FAIL mid_ready: a_ready=%b b_ready=%b, expected 0 0", a_ready, b_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (WriteReg !== 1'b0 || DstReg !== 4'd0 || DstData !== 16'd0 || busy_vec !== 16'h0000 || rsv_err !== 1'b0) begin
            $display("FAIL mid_out: WriteReg=%b DstReg=%0d DstData=%h busy_vec=%h rsv_err=%b, expected all 0", WriteReg, DstReg, DstData, busy_vec, rsv_err);
            miscompares++;
        end
        rst = 1;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            $display("FAIL mid_norm: a_ready=%b b_ready=%b, expected 1 0", a_ready, b_ready);
            miscompares++;
        end
        $display("test_reset_mid done");
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_priority();
        test_wait_clear();
        test_reservation();
        test_double_rsv();
        test_same_edge();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
